// File: rtl/slc3_mem_pkg.sv
// Shared types, bus widths and boot image for the SLC-3 SRAM responder.
// The image is loaded only when SLC3_SRAM_INIT_IMAGE_EN is defined.
package slc3_mem_pkg;

    typedef enum logic {
        INIT,
        SERVE
    } state_t;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;
    localparam int IMAGE_WORDS = 32;

    localparam logic [SRAM_DATA_W-1:0] INIT_IMAGE [IMAGE_WORDS] = '{
        16'h1234, 16'h5678, 16'h9ABC, 16'h0F0F,
        16'h5020, 16'h1221, 16'h1422, 16'h16BF,
        16'h0BFD, 16'h3005, 16'h2204, 16'h1641,
        16'h0402, 16'h0FFA, 16'hF025, 16'h0000,
        16'h0005, 16'h0003, 16'hE002, 16'h6200,
        16'h1261, 16'h7200, 16'h0FFC, 16'hF025,
        16'h3100, 16'h0001, 16'h0002, 16'h0003,
        16'h0004, 16'h0005, 16'h0006, 16'h0000
    };

    function automatic logic [SRAM_DATA_W-1:0] image(
        input int i,
        input int len
    );
        if (i < len && i < IMAGE_WORDS)
            return INIT_IMAGE[i[4:0]];
        return '0;
    endfunction

endpackage

// File: rtl/slc3_sram_array.sv
// Single-port word RAM with per-byte write enables and registered read.
// Shaped so synthesis can map it onto block RAM.
module slc3_sram_array
    import slc3_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             we,
    input  logic                   re,
    input  logic [DEPTH_LOG2-1:0]  addr,
    input  logic [SRAM_DATA_W-1:0] wdata,
    output logic [SRAM_DATA_W-1:0] rdata
);

    logic [SRAM_DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we[1])
            mem[addr][15:8] <= wdata[15:8];
        if (we[0])
            mem[addr][7:0] <= wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/slc3_sram_responder.sv
// Memory-side responder for the SLC-3 external SRAM bus.
// Boot-image preload is built in with SLC3_SRAM_INIT_IMAGE_EN.
module slc3_sram_responder
    import slc3_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int INIT_LEN   = 32
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   CE,
    input  logic                   OE,
    input  logic                   WE,
    input  logic                   UB,
    input  logic                   LB,
    input  logic [SRAM_ADDR_W-1:0] ADDR,
    inout  wire  [SRAM_DATA_W-1:0] Data,
    output logic                   Ready
);

    logic                   serve;
    logic                   init_wr;
    logic [DEPTH_LOG2-1:0]  cnt;
    logic                   bus_wr;
    logic                   bus_rd;
    logic                   drive;
    logic [1:0]             lane;
    logic [1:0]             den;
    logic [1:0]             mem_we;
    logic [DEPTH_LOG2-1:0]  mem_addr;
    logic [SRAM_DATA_W-1:0] mem_wdata;
    logic [SRAM_DATA_W-1:0] rdata;
    logic                   unused_ok;

`ifdef SLC3_SRAM_INIT_IMAGE_EN
    state_t                state;
    state_t                state_nx;
    logic [DEPTH_LOG2-1:0] cnt_nx;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= INIT;
            cnt   <= '0;
            Ready <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            Ready <= (state_nx == SERVE);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            INIT: begin
                cnt_nx = cnt + 1'b1;
                if (&cnt)
                    state_nx = SERVE;
            end
            SERVE: ;
        endcase
    end

    assign serve   = ~Reset & (state == SERVE);
    assign init_wr = ~Reset & (state == INIT);
`else
    always_ff @(posedge Clk) begin
        if (Reset)
            Ready <= 1'b0;
        else
            Ready <= 1'b1;
    end

    assign cnt     = '0;
    assign serve   = ~Reset;
    assign init_wr = 1'b0;
`endif

    // WE low always means write, so a read needs WE high
    assign lane   = ~{UB, LB};
    assign bus_wr = serve & ~CE & ~WE;
    assign bus_rd = serve & ~CE & WE & ~OE;

    always_ff @(posedge Clk) begin
        if (Reset)
            den <= '0;
        else
            den <= bus_rd ? lane : 2'b00;
    end

    always_comb begin
        mem_we    = bus_wr ? lane : 2'b00;
        mem_addr  = ADDR[DEPTH_LOG2-1:0];
        mem_wdata = Data;
        if (init_wr) begin
            mem_we    = 2'b11;
            mem_addr  = cnt;
            mem_wdata = image(int'(cnt), INIT_LEN);
        end
    end

    slc3_sram_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (Clk),
        .rst  (Reset),
        .we   (mem_we),
        .re   (bus_rd),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .rdata(rdata)
    );

    // release is combinational so a starting write never collides
    assign drive = ~CE & ~OE & WE;

    assign Data[15:8] = (drive & den[1]) ? rdata[15:8] : 8'hzz;
    assign Data[7:0]  = (drive & den[0]) ? rdata[7:0]  : 8'hzz;

    assign unused_ok = ^{ADDR[SRAM_ADDR_W-1:DEPTH_LOG2], INIT_LEN[0]};

endmodule
